// File: rtl/data_memory_wb.sv
// Word-addressed data memory with a posted FIFO store buffer; loads are combinational (0 cycles) and forward the youngest buffered store.
// Never stalls the core: the buffer drains on read-free cycles, and a store into a full buffer forces a drain in the same cycle.
module data_memory_wb #(
    parameter int WORDS    = 1024,
    parameter int WB_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [31:0]                 address,
    input  logic [31:0]                 writeData,
    input  logic                        MemRead,
    input  logic                        MemWrite,
    output logic [31:0]                 readData,
    output logic [$clog2(WB_DEPTH):0]   wbCount,
    output logic                        wbEmpty
);
    localparam int AW = $clog2(WORDS);
    localparam int PW = $clog2(WB_DEPTH);

    logic [AW-1:0]  idx;
    logic [AW-1:0]  ent_idx_q [WB_DEPTH];
    logic [31:0]    ent_dat_q [WB_DEPTH];
    logic [31:0]    mem_q     [WORDS];
    logic [PW-1:0]  head_q, head_d;
    logic [PW-1:0]  tail_q, tail_d;
    logic [PW:0]    count_q, count_d;
    logic           drain;
    logic           enq;
    logic           fwd_hit;
    logic [31:0]    fwd_dat;
    logic           unused_addr_bits;

    assign idx              = address[AW+1:2];
    assign unused_addr_bits = ^{address[31:AW+2], address[1:0]};

    assign enq   = MemWrite;
    assign drain = (count_q != '0) &&
                   (!MemRead || ((count_q == (PW+1)'(WB_DEPTH)) && MemWrite));

    // Walk oldest to youngest so the last match seen is the youngest store.
    always_comb begin
        fwd_hit = 1'b0;
        fwd_dat = '0;
        for (int k = 0; k < WB_DEPTH; k++) begin
            if (((PW+1)'(k) < count_q) && (ent_idx_q[head_q + PW'(k)] == idx)) begin
                fwd_hit = 1'b1;
                fwd_dat = ent_dat_q[head_q + PW'(k)];
            end
        end
    end

    always_comb begin
        readData = '0;
        if (MemRead) begin
            readData = fwd_hit ? fwd_dat : mem_q[idx];
        end
    end

    always_comb begin
        head_d  = drain ? head_q + PW'(1) : head_q;
        tail_d  = enq   ? tail_q + PW'(1) : tail_q;
        count_d = count_q;
        if (enq && !drain) begin
            count_d = count_q + (PW+1)'(1);
        end else if (drain && !enq) begin
            count_d = count_q - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry payload needs no reset: occupancy is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (rst && enq) begin
            ent_idx_q[tail_q] <= idx;
            ent_dat_q[tail_q] <= writeData;
        end
    end

    // When full, tail equals head; the RAM takes the old head before it is overwritten.
    always_ff @(posedge clk) begin
        if (rst && drain) begin
            mem_q[ent_idx_q[head_q]] <= ent_dat_q[head_q];
        end
    end

    assign wbCount = count_q;
    assign wbEmpty = (count_q == '0);
endmodule

// File: tb/tb_data_memory_wb.sv
// Bench for data_memory_wb: directed scenarios plus random traffic against a queue-based memory model.
module tb_data_memory_wb;
    localparam int WORDS    = 1024;
    localparam int WB_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] writeData = '0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] readData;
    logic [2:0]  wbCount;
    logic        wbEmpty;

    data_memory_wb #(.WORDS(WORDS), .WB_DEPTH(WB_DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .address   (address),
        .writeData (writeData),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .readData  (readData),
        .wbCount   (wbCount),
        .wbEmpty   (wbEmpty)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned idx;
        logic [31:0] dat;
    } st_t;

    st_t         pend[$];
    logic [31:0] ram_m [WORDS];
    logic [31:0] pre_v [32];
    bit          model_ok = 1'b0;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int unsigned widx(input logic [31:0] a);
        return (a >> 2) % WORDS;
    endfunction

    function automatic logic [31:0] exp_read(input bit rd, input logic [31:0] a);
        int unsigned i;
        if (!rd) return 32'h0;
        i = widx(a);
        for (int k = pend.size() - 1; k >= 0; k--) begin
            if (pend[k].idx == i) return pend[k].dat;
        end
        return ram_m[i];
    endfunction

    // Apply inputs mid-cycle and compare the combinational outputs against the model.
    task automatic drive(input bit r, input bit rd, input bit wr,
                         input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        rst = r; MemRead = rd; MemWrite = wr; address = a; writeData = d;
        #1;
        if (model_ok) begin
            chk("readData", readData, exp_read(rd, a));
            chk("wbCount", 32'(wbCount), 32'(pend.size()));
            chk("wbEmpty", 32'(wbEmpty), 32'(pend.size() == 0));
        end
    endtask

    task automatic step();
        st_t e;
        @(posedge clk);
        if (!rst) begin
            pend.delete();
            model_ok = 1'b1;
        end else begin
            if (pend.size() > 0 &&
                (!MemRead || (pend.size() == WB_DEPTH && MemWrite))) begin
                ram_m[pend[0].idx] = pend[0].dat;
                void'(pend.pop_front());
            end
            if (MemWrite) begin
                e.idx = widx(address);
                e.dat = writeData;
                pend.push_back(e);
            end
        end
    endtask

    task automatic cyc(input bit r, input bit rd, input bit wr,
                       input logic [31:0] a, input logic [31:0] d);
        drive(r, rd, wr, a, d);
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] v;

        cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("reset_count", 32'(wbCount), 32'd0);
        chk("reset_empty", 32'(wbEmpty), 32'd1);
        chk("reset_rd0", readData, 32'h0);
        step();

        for (int i = 0; i < 32; i++) begin
            v = $urandom;
            pre_v[i] = v;
            cyc(1'b1, 1'b0, 1'b1, 32'(i * 4), v);
        end
        idle(3);

        // Store then immediately load: forwarded from the buffer.
        cyc(1'b1, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        drive(1'b1, 1'b1, 1'b0, 32'h10, 32'h0);
        chk("fwd_data", readData, 32'hDEADBEEF);
        chk("fwd_count", 32'(wbCount), 32'd1);
        step();
        idle(1);
        drive(1'b1, 1'b1, 1'b0, 32'h10, 32'h0);
        chk("fwd_drained_count", 32'(wbCount), 32'd0);
        chk("fwd_ram_data", readData, 32'hDEADBEEF);
        step();

        // Two stores to one index with reads holding off drain.
        cyc(1'b1, 1'b1, 1'b1, 32'h20, 32'd1);
        cyc(1'b1, 1'b1, 1'b1, 32'h20, 32'd2);
        drive(1'b1, 1'b1, 1'b0, 32'h20, 32'h0);
        chk("youngest_fwd", readData, 32'd2);
        step();
        idle(4);
        drive(1'b1, 1'b1, 1'b0, 32'h20, 32'h0);
        chk("youngest_ram", readData, 32'd2);
        step();

        // Full buffer: fifth store forces the oldest out.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 1'b1, 32'(i * 4), 32'hA + 32'(i));
            if (i == 4) chk("full_sat", 32'(wbCount), 32'd4);
            step();
        end
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
        chk("full_ram0", readData, 32'hA);
        chk("full_stay4", 32'(wbCount), 32'd4);
        step();
        for (int i = 1; i < 5; i++) begin
            drive(1'b1, 1'b1, 1'b0, 32'(i * 4), 32'h0);
            chk("full_fwd", readData, 32'hA + 32'(i));
            step();
        end
        idle(5);

        // Same-cycle read and write returns the pre-store value.
        cyc(1'b1, 1'b0, 1'b1, 32'hC, 32'd7);
        idle(2);
        drive(1'b1, 1'b1, 1'b1, 32'hC, 32'd9);
        chk("rw_old", readData, 32'd7);
        step();
        drive(1'b1, 1'b1, 1'b0, 32'hC, 32'h0);
        chk("rw_new", readData, 32'd9);
        step();
        idle(3);

        // Reset with undrained stores discards them.
        for (int i = 24; i < 27; i++) cyc(1'b1, 1'b1, 1'b1, 32'(i * 4), 32'h5A5A0000 + 32'(i));
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 24; i < 27; i++) begin
            drive(1'b1, 1'b1, 1'b0, 32'(i * 4), 32'h0);
            chk("rst_count", 32'(wbCount), 32'd0);
            chk("rst_old", readData, pre_v[i]);
            step();
        end

        // Random traffic over a narrow index range to provoke collisions and wrap.
        for (int n = 0; n < 1500; n++) begin
            a = ($urandom & 32'hFFFFF003) | (32'($urandom_range(0, 15)) << 2);
            cyc($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 1) != 0, a, $urandom);
        end
        idle(6);
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b1, 1'b0, 32'(i * 4), 32'h0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
